my_dff_en: RTL and testbench



---
 rtl/my_dff_en_pkg.sv | 7 +
 rtl/my_dff_en.sv | 38 +++
 tb/tb_my_dff_en.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/my_dff_en_pkg.sv
// Shared datapath constants for the fixed-point pipeline registers.
package my_dff_en_pkg;

  // Default fixed-point operand width used across the ML datapath.
  localparam int unsigned FIXP_W = 12;

endpackage : my_dff_en_pkg

// File: rtl/my_dff_en.sv
// Parameterised D flip-flop bank with synchronous load-enable and asynchronous
// active-low clear; out is driven straight from the flops.
module my_dff_en
  import my_dff_en_pkg::*;
#(
  parameter int unsigned          WIDTH       = FIXP_W,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;

  // Load d when enabled, otherwise recirculate the stored value.
  always_comb begin
    out_d = out_q;
    if (enable) begin
      out_d = d;
    end
  end

  // Reset dominates: enable is never looked at while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= RESET_VALUE;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule : my_dff_en

// File: tb/tb_my_dff_en.sv
// Directed self-checking bench for my_dff_en at the default 12-bit width.
module tb_my_dff_en;

  localparam int unsigned W = 12;

  logic         clk;
  logic         rst;
  logic         enable;
  logic [W-1:0] d;
  logic [W-1:0] out;

  int checks;
  int errors;

  my_dff_en #(
    .WIDTH       (W),
    .RESET_VALUE (12'h000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .d      (d),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle to the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [W-1:0] vals [4];
    vals[0] = 12'h345; vals[1] = 12'h04A; vals[2] = 12'h111; vals[3] = 12'h400;
    rst = 1'b0;
    #1;
    checks++;
    if (out !== 12'h000) begin
      errors++;
      $display("FAIL reset_assert: out=%h expected=%h", out, 12'h000);
    end
    for (int i = 0; i < 4; i++) begin
      d = vals[i];
      enable = 1'b0;
      tick();
      checks++;
      if (out !== 12'h000) begin
        errors++;
        $display("FAIL reset_hold[%0d]: out=%h expected=%h", i, out, 12'h000);
      end
      enable = 1'b1;
      tick();
      checks++;
      if (out !== 12'h000) begin
        errors++;
        $display("FAIL reset_hold_en[%0d]: out=%h expected=%h", i, out, 12'h000);
      end
    end
  endtask

  task automatic test_hold_after_release();
    enable = 1'b0;
    d = 12'h876;
    rst = 1'b1;
    #1;
    checks++;
    if (out !== 12'h000) begin
      errors++;
      $display("FAIL release_no_change: out=%h expected=%h", out, 12'h000);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) d = 12'hABC;
      tick();
      checks++;
      if (out !== 12'h000) begin
        errors++;
        $display("FAIL hold_after_release[%0d]: out=%h expected=%h", i, out, 12'h000);
      end
    end
  endtask

  task automatic test_load();
    enable = 1'b1;
    d = 12'hABC;
    tick();
    checks++;
    if (out !== 12'hABC) begin
      errors++;
      $display("FAIL load_abc: out=%h expected=%h", out, 12'hABC);
    end
    d = 12'h04A;
    #2;
    checks++;
    if (out !== 12'hABC) begin
      errors++;
      $display("FAIL no_bypass: out=%h expected=%h", out, 12'hABC);
    end
    tick();
    checks++;
    if (out !== 12'h04A) begin
      errors++;
      $display("FAIL load_04a: out=%h expected=%h", out, 12'h04A);
    end
  endtask

  task automatic test_enable_gating();
    enable = 1'b0;
    d = 12'h111;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out !== 12'h04A) begin
        errors++;
        $display("FAIL gate_hold[%0d]: out=%h expected=%h", i, out, 12'h04A);
      end
    end
    enable = 1'b1;
    tick();
    checks++;
    if (out !== 12'h111) begin
      errors++;
      $display("FAIL gate_load: out=%h expected=%h", out, 12'h111);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] vals [5];
    vals[0] = 12'hFFF; vals[1] = 12'h000; vals[2] = 12'h800;
    vals[3] = 12'h001; vals[4] = 12'h5A5;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = vals[i];
      tick();
      checks++;
      if (out !== vals[i]) begin
        errors++;
        $display("FAIL back_to_back[%0d]: out=%h expected=%h", i, out, vals[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    enable = 1'b1;
    d = 12'h876;
    tick();
    checks++;
    if (out !== 12'h876) begin
      errors++;
      $display("FAIL async_preload: out=%h expected=%h", out, 12'h876);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out !== 12'h000) begin
      errors++;
      $display("FAIL async_clear: out=%h expected=%h", out, 12'h000);
    end
    @(negedge clk);
    checks++;
    if (out !== 12'h000) begin
      errors++;
      $display("FAIL async_stays: out=%h expected=%h", out, 12'h000);
    end
  endtask

  task automatic test_priority();
    rst = 1'b0;
    enable = 1'b1;
    d = 12'hFFF;
    tick();
    checks++;
    if (out !== 12'h000) begin
      errors++;
      $display("FAIL priority_rst: out=%h expected=%h", out, 12'h000);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out !== 12'h000) begin
      errors++;
      $display("FAIL priority_release: out=%h expected=%h", out, 12'h000);
    end
    tick();
    checks++;
    if (out !== 12'hFFF) begin
      errors++;
      $display("FAIL priority_first_load: out=%h expected=%h", out, 12'hFFF);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    enable = 1'b0;
    d      = '0;
    @(negedge clk);
    test_reset();
    test_hold_after_release();
    test_load();
    test_enable_gating();
    test_back_to_back();
    test_async_reset();
    test_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_my_dff_en
